char_buf_arbiter: RTL and testbench

CHAR_BUF_ARBITER -- requirements
Module: char_buf_arbiter

---
 rtl/char_buf_arbiter.sv | 162 ++++++++++++++++
 tb/tb_char_buf_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_arbiter.sv
// char_buf_arbiter
//   Shares one character RAM port between the display scan-out, a character
//   write requester (with a text cursor) and a whole-screen clear engine.
//   The display always wins the RAM in its slot cycles; writes and clear
//   steps only use the cycles in between.
// Ports
//   clk, rst              pixel clock, asynchronous active-high reset
//   counter_x, counter_y  scan position from the sync generator
//   wr_valid/wr_char/wr_ready  character write handshake (0x0D = CR)
//   clr_req               request a clear of the whole screen to spaces
//   ram_addr/ram_we/ram_wdata/ram_rdata  character RAM port (1-cycle read)
//   disp_char/disp_valid  character for the scanned cell, pulse on update
//   cur_col, cur_row      text cursor
//   busy                  high while a clear is in progress
module char_buf_arbiter #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int CELL_W = 8,
    parameter int CELL_H = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  counter_x,
    input  logic [9:0]  counter_y,
    input  logic        wr_valid,
    input  logic [7:0]  wr_char,
    output logic        wr_ready,
    input  logic        clr_req,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  disp_char,
    output logic        disp_valid,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
    localparam logic [11:0] CLR_LAST = 12'(COLS * ROWS - 1);
    localparam logic [7:0]  CHAR_CR  = 8'h0D;
    localparam logic [7:0]  CHAR_SP  = 8'h20;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] clr_addr_q, clr_addr_d;
    logic        slot_dly_q, slot_dly_d;
    logic [7:0]  disp_char_q, disp_char_d;
    logic        disp_valid_q, disp_valid_d;

    logic        slot;
    logic [11:0] disp_addr;
    logic [11:0] cur_addr;
    logic [4:0]  row_inc;

    always_comb begin
        slot      = (counter_x < 10'd640) && (counter_y < 10'd480) &&
                    (counter_x[2:0] == 3'd0);
        disp_addr = 12'((32'(counter_y) / CELL_H) * COLS + 32'(counter_x) / CELL_W);
        cur_addr  = 12'(32'(row_q) * COLS + 32'(col_q));
        row_inc   = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    end

    // Read data arrives the cycle after the slot; register it on that cycle
    // so disp_char/disp_valid show up two cycles after the slot.
    always_comb begin
        slot_dly_d   = slot;
        disp_valid_d = slot_dly_q;
        disp_char_d  = slot_dly_q ? ram_rdata : disp_char_q;
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        clr_addr_d = clr_addr_q;
        wr_ready   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;

        if (slot)
            ram_addr = disp_addr;

        case (state_q)
            IDLE: begin
                // A clear request blocks the handshake in the same cycle.
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end else if (!slot) begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        if (wr_char == CHAR_CR) begin
                            col_d = '0;
                            row_d = row_inc;
                        end else begin
                            ram_we    = 1'b1;
                            ram_addr  = cur_addr;
                            ram_wdata = wr_char;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_inc;
                            end else begin
                                col_d = col_q + 7'd1;
                            end
                        end
                    end
                end
            end
            CLEAR: begin
                // Slot cycles stall the walk; the display keeps the RAM.
                if (!slot) begin
                    ram_we    = 1'b1;
                    ram_addr  = clr_addr_q;
                    ram_wdata = CHAR_SP;
                    if (clr_addr_q == CLR_LAST) begin
                        state_d    = IDLE;
                        col_d      = '0;
                        row_d      = '0;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + 12'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            clr_addr_q   <= '0;
            slot_dly_q   <= 1'b0;
            disp_char_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            clr_addr_q   <= clr_addr_d;
            slot_dly_q   <= slot_dly_d;
            disp_char_q  <= disp_char_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign disp_char  = disp_char_q;
    assign disp_valid = disp_valid_q;
    assign cur_col    = col_q;
    assign cur_row    = row_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Testbench for char_buf_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a linear-cursor reference model.
module tb_char_buf_arbiter;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int TOTAL = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  counter_x, counter_y;
    logic        wr_valid;
    logic [7:0]  wr_char;
    logic        wr_ready;
    logic        clr_req;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  disp_char;
    logic        disp_valid;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    char_buf_arbiter #(.COLS(COLS), .ROWS(ROWS), .CELL_W(8), .CELL_H(16)) dut (
        .clk(clk), .rst(rst), .counter_x(counter_x), .counter_y(counter_y),
        .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
        .clr_req(clr_req), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .disp_char(disp_char),
        .disp_valid(disp_valid), .cur_col(cur_col), .cur_row(cur_row),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: cursor as a linear screen position.
    int m_busy = 0;
    int m_pos  = 0;
    int m_clr  = 0;
    int v1 = 0, v2 = 0;
    int c2 = 0;
    int clr_writes = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_pos = 0; m_clr = 0; v1 = 0; v2 = 0; c2 = 0;
    endtask

    // One clock: check at the falling edge, advance the model, return 1ns
    // after the next rising edge so the caller can drive new inputs.
    task automatic step();
        int cx, cy, slot, daddr, e_we, e_addr, e_wd, e_rdy;
        @(negedge clk);
        cx = int'(counter_x); cy = int'(counter_y);
        slot  = (cx < 640 && cy < 480 && cx % 8 == 0) ? 1 : 0;
        daddr = (cy / 16) * COLS + cx / 8;
        e_we = 0; e_addr = slot ? daddr : 0; e_wd = 0; e_rdy = 0;
        if (m_busy != 0) begin
            if (slot == 0) begin e_we = 1; e_addr = m_clr; e_wd = 'h20; end
        end else if (clr_req == 1'b0 && slot == 0) begin
            e_rdy = 1;
            if (wr_valid && wr_char != 8'h0D) begin
                e_we = 1; e_addr = m_pos; e_wd = int'(wr_char);
            end
        end
        chk("wr_ready",  int'(wr_ready),  e_rdy);
        chk("ram_we",    int'(ram_we),    e_we);
        chk("ram_addr",  int'(ram_addr),  e_addr);
        chk("ram_wdata", int'(ram_wdata), e_wd);
        chk("busy",      int'(busy),      m_busy);
        chk("cur_col",   int'(cur_col),   m_pos % COLS);
        chk("cur_row",   int'(cur_row),   m_pos / COLS);
        chk("disp_valid", int'(disp_valid), v2);
        if (v2 != 0) chk("disp_char", int'(disp_char), c2);
        if (m_busy != 0 && ram_we) clr_writes++;

        v2 = v1; c2 = int'(ram_rdata); v1 = slot;
        if (m_busy != 0) begin
            if (slot == 0) begin
                if (m_clr == TOTAL - 1) begin m_busy = 0; m_pos = 0; m_clr = 0; end
                else m_clr++;
            end
        end else if (clr_req) begin
            m_busy = 1; m_clr = 0;
        end else if (slot == 0 && wr_valid) begin
            if (wr_char == 8'h0D) m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
            else m_pos = (m_pos + 1) % TOTAL;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_counters();
        counter_x = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 99) * 8)
                                                : 10'($urandom_range(0, 799));
        counter_y = 10'($urandom_range(0, 524));
        ram_rdata = 8'($urandom);
    endtask

    function automatic logic [7:0] rand_ch();
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        if (c == 8'h0D) c = 8'h0E;
        return c;
    endfunction

    // Drive a character in a non-slot cycle.
    task automatic put(input logic [7:0] c);
        counter_x = 10'd1; counter_y = 10'd0; ram_rdata = 8'($urandom);
        wr_valid = 1'b1; wr_char = c; clr_req = 1'b0;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        counter_x = 10'd1; counter_y = 10'd0; wr_valid = 1'b0; wr_char = 8'h00;
        clr_req = 1'b0; ram_rdata = 8'h00;
        model_reset();
        #3;
        chk("rst_busy",  int'(busy), 0);
        chk("rst_col",   int'(cur_col), 0);
        chk("rst_row",   int'(cur_row), 0);
        chk("rst_dvld",  int'(disp_valid), 0);
        chk("rst_dchar", int'(disp_char), 0);
        #4 rst = 1'b0;

        // Display fetch: cell (2,2) -> address 162, data 0x41 a cycle later.
        counter_x = 10'd16; counter_y = 10'd32;
        step();
        counter_x = 10'd1; ram_rdata = 8'h41;
        step();
        ram_rdata = 8'h00;
        step();
        chk("fetch_char", int'(disp_char), 'h41);

        // 'H','I' at the home position.
        put(8'h48);
        put(8'h49);
        chk("hi_col", int'(cur_col), 2);

        // Fill up to the last cell, then wrap.
        guard = 0;
        while (m_pos != TOTAL - 1 && guard < 5000) begin put(rand_ch()); guard++; end
        chk("at_last", m_pos, TOTAL - 1);
        put(8'h5A);
        chk("wrap_col", int'(cur_col), 0);
        chk("wrap_row", int'(cur_row), 0);

        // CR from (5,3).
        while (m_pos != 3 * COLS + 5) put(rand_ch());
        put(8'h0D);
        chk("cr_col", int'(cur_col), 0);
        chk("cr_row", int'(cur_row), 4);

        // Write offered in a slot cycle, accepted the next non-slot cycle.
        counter_x = 10'd8; counter_y = 10'd0; wr_valid = 1'b1; wr_char = 8'h33;
        step();
        counter_x = 10'd9;
        step();
        wr_valid = 1'b0;
        chk("slot_defer_col", int'(cur_col), 1);

        // Clear and write together: clear wins.
        counter_x = 10'd1; counter_y = 10'd0; clr_req = 1'b1; wr_valid = 1'b1; wr_char = 8'h41;
        clr_writes = 0;
        step();
        guard = 0;
        while (m_busy != 0 && guard < 8000) begin
            rand_counters();
            clr_req = 1'($urandom_range(0, 1)); wr_valid = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        chk("clr_timeout", m_busy, 0);
        chk("clr_writes", clr_writes, TOTAL);
        chk("clr_col", int'(cur_col), 0);
        chk("clr_row", int'(cur_row), 0);

        // Reset in the middle of a clear.
        clr_req = 1'b1; wr_valid = 1'b0; counter_x = 10'd1;
        step();
        clr_req = 1'b0;
        guard = 0;
        while (m_clr != 1000 && guard < 4000) begin rand_counters(); step(); guard++; end
        chk("clr_reach", m_clr, 1000);
        clr_req = 1'b0; wr_valid = 1'b0; counter_x = 10'd1;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_col",  int'(cur_col), 0);
        chk("mid_rst_dv",   int'(disp_valid), 0);
        model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            rand_counters();
            clr_req = 1'b0; wr_valid = 1'b0;
        end

        // Random traffic.
        for (int i = 0; i < 15000; i++) begin
            rand_counters();
            wr_valid = 1'($urandom_range(0, 1));
            wr_char  = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
            clr_req  = ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
